// File: rtl/pulse_width_pkg.sv
// pulse_width_pkg
//   Shared definitions for the pulse width meter.
//   - state_e      : measurement FSM states (MEAS_LO is only reachable when
//                    the meter is built with PULSE_WIDTH_METER_LOW_EN)
//   - DefCntWidth  : default counter / width_o width
// The result record is a packed struct declared inside pulse_width_slot,
// because its width follows the CntWidth parameter of the instance.
package pulse_width_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEAS_HI = 2'd1,
    MEAS_LO = 2'd2
  } state_e;

  localparam int unsigned DefCntWidth = 16;

endpackage

// File: rtl/pulse_width_slot.sv
// pulse_width_slot
//   Single-entry result holding register with drop detection.
//   Ports:
//     clk_i, rst_ni        clock, asynchronous active-low reset
//     clr_i                synchronous clear, highest priority
//     load_i               a measurement completed this cycle
//     width_i/level_i/sat_i  the completed measurement
//     ready_i              consumer accepts the held result
//     valid_o              a result is held
//     width_o/level_o/sat_o  the held result
//     drop_o               one-cycle pulse: a completed result was discarded
//
// Handshake: a transfer happens on every cycle with valid_o & ready_i. While
// valid_o & !ready_i the held result is frozen. A completion is accepted when
// the slot is empty or is being drained in the same cycle; otherwise it is
// discarded and drop_o pulses on the following cycle.
module pulse_width_slot #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] width_i,
  input  logic             level_i,
  input  logic             sat_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [Width-1:0] width_o,
  output logic             level_o,
  output logic             sat_o,
  output logic             drop_o
);

  typedef struct packed {
    logic [Width-1:0] width;
    logic             level;
    logic             sat;
  } result_t;

  result_t slot_q;
  logic    valid_q;
  logic    drop_q;
  logic    accept;

  // Slot can take a new result if empty or emptying this cycle.
  assign accept = ~valid_q | ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else if (clr_i) begin
      slot_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= load_i & ~accept;
      if (load_i && accept) begin
        slot_q  <= '{width: width_i, level: level_i, sat: sat_i};
        valid_q <= 1'b1;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o = valid_q;
  assign width_o = slot_q.width;
  assign level_o = slot_q.level;
  assign sat_o   = slot_q.sat;
  assign drop_o  = drop_q;

endmodule

// File: rtl/pulse_width_meter.sv
// pulse_width_meter
//   Measures the width in clock cycles of high pulses (and low pulses when
//   built with `define PULSE_WIDTH_METER_LOW_EN) from upstream edge strobes,
//   offering each completed measurement on a single-entry valid/ready port.
//   Ports:
//     clk_i, rst_ni      clock, asynchronous active-low reset
//     clr_i              synchronous clear, overrides every other input
//     en_i               measurement enable; low aborts a running measurement
//     r_edge_i, f_edge_i one-cycle rising / falling edge strobes
//     width_o            measured width (all ones when saturated)
//     level_o            pulse polarity, 1 = high
//     sat_o              width saturated; qualified by valid_o
//     valid_o, ready_i   result handshake
//     drop_o             one-cycle pulse: a completed result was discarded
//     state_o            current FSM state (debug)
//   Width counts from the start-edge cycle (inclusive) to the end-edge cycle
//   (exclusive); the result is visible the cycle after the end edge.
module pulse_width_meter
  import pulse_width_pkg::*;
#(
  parameter int unsigned CntWidth = DefCntWidth
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic                r_edge_i,
  input  logic                f_edge_i,
  output logic [CntWidth-1:0] width_o,
  output logic                level_o,
  output logic                sat_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                drop_o,
  output state_e              state_o
);

  localparam logic [CntWidth-1:0] SatVal  = {CntWidth{1'b1}};
  localparam logic [CntWidth-1:0] SatPrev = {{(CntWidth-1){1'b1}}, 1'b0};
  localparam logic [CntWidth-1:0] CntOne  = {{(CntWidth-1){1'b0}}, 1'b1};

  state_e              state_q;
  logic [CntWidth-1:0] cnt_q;
  logic                sat_q;  // set exactly when cnt_q has hit SatVal
  logic                done;
  logic                done_level;

  // A measurement completes on the terminating edge while still enabled;
  // an enable drop in the same cycle aborts instead.
  always_comb begin
    done       = 1'b0;
    done_level = 1'b1;
    case (state_q)
      MEAS_HI: done = en_i & f_edge_i;
`ifdef PULSE_WIDTH_METER_LOW_EN
      MEAS_LO: begin
        done       = en_i & r_edge_i;
        done_level = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else if (clr_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Rising edge wins over a simultaneous falling edge.
          if (en_i && r_edge_i) begin
            state_q <= MEAS_HI;
            cnt_q   <= CntOne;
            sat_q   <= 1'b0;
`ifdef PULSE_WIDTH_METER_LOW_EN
          end else if (en_i && f_edge_i) begin
            state_q <= MEAS_LO;
            cnt_q   <= CntOne;
            sat_q   <= 1'b0;
`endif
          end
        end
        MEAS_HI: begin
          if (!en_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
          end else if (f_edge_i) begin
`ifdef PULSE_WIDTH_METER_LOW_EN
            state_q <= MEAS_LO;
            cnt_q   <= CntOne;
`else
            state_q <= IDLE;
            cnt_q   <= '0;
`endif
            sat_q   <= 1'b0;
          end else if (cnt_q != SatVal) begin
            // Stray rising edges land here and are ignored.
            cnt_q <= cnt_q + CntOne;
            if (cnt_q == SatPrev) sat_q <= 1'b1;
          end
        end
`ifdef PULSE_WIDTH_METER_LOW_EN
        MEAS_LO: begin
          if (!en_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
          end else if (r_edge_i) begin
            state_q <= MEAS_HI;
            cnt_q   <= CntOne;
            sat_q   <= 1'b0;
          end else if (cnt_q != SatVal) begin
            cnt_q <= cnt_q + CntOne;
            if (cnt_q == SatPrev) sat_q <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          sat_q   <= 1'b0;
        end
      endcase
    end
  end

  pulse_width_slot #(
    .Width (CntWidth)
  ) u_slot (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .load_i  (done),
    .width_i (cnt_q),
    .level_i (done_level),
    .sat_i   (sat_q),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .width_o (width_o),
    .level_o (level_o),
    .sat_o   (sat_o),
    .drop_o  (drop_o)
  );

  assign state_o = state_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb_pulse_width_meter
//   Directed bench for pulse_width_meter with CntWidth = 4 so saturation is
//   reachable quickly. Inputs change 1 time unit after a rising edge and
//   outputs are sampled at that same point, i.e. they show the state
//   registered on the edge just taken.
module tb_pulse_width_meter;
  import pulse_width_pkg::*;

  localparam int unsigned CntWidth = 4;

  logic                clk;
  logic                rst_n;
  logic                clr;
  logic                en;
  logic                r_edge;
  logic                f_edge;
  logic                ready;
  logic [CntWidth-1:0] width;
  logic                level;
  logic                sat;
  logic                valid;
  logic                drop;
  state_e              state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [CntWidth-1:0] exp_q[$];

  pulse_width_meter #(
    .CntWidth (CntWidth)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clr_i    (clr),
    .en_i     (en),
    .r_edge_i (r_edge),
    .f_edge_i (f_edge),
    .width_o  (width),
    .level_o  (level),
    .sat_o    (sat),
    .valid_o  (valid),
    .ready_i  (ready),
    .drop_o   (drop),
    .state_o  (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Pops the expected width and compares the whole held result.
  task automatic check_result(input string tag, input logic lvl, input logic st);
    logic [CntWidth-1:0] w;
    if (exp_q.size() == 0) begin
      check({tag, "_exp_q_empty"}, 32'd1, 32'd0);
    end else begin
      w = exp_q.pop_front();
      check({tag, "_valid"}, 32'(valid), 32'd1);
      check({tag, "_width"}, 32'(width), 32'(w));
      check({tag, "_level"}, 32'(level), 32'(lvl));
      check({tag, "_sat"},   32'(sat),   32'(st));
    end
  endtask

  // driver: one clock cycle with the given edge strobes
  task automatic tick(input logic r, input logic f);
    r_edge = r;
    f_edge = f;
    @(posedge clk);
    #1;
    r_edge = 1'b0;
    f_edge = 1'b0;
  endtask

  // rising edge, w-1 high cycles, falling edge -> width w
  task automatic pulse(input int w);
    tick(1'b1, 1'b0);
    repeat (w - 1) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
  endtask

  initial begin
    rst_n  = 1'b0;
    clr    = 1'b0;
    en     = 1'b1;
    r_edge = 1'b0;
    f_edge = 1'b0;
    ready  = 1'b1;
    #22;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_width", 32'(width), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_sat",   32'(sat),   32'd0);
    check("rst_drop",  32'(drop),  32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifndef PULSE_WIDTH_METER_LOW_EN
    // basic width 5, one-cycle valid with ready high
    exp_q.push_back(4'd5);
    pulse(5);
    check_result("w5", 1'b1, 1'b0);
    check("w5_state", 32'(state), 32'(IDLE));
    tick(1'b0, 1'b0);
    check("w5_valid_clr", 32'(valid), 32'd0);

    // saturation: 20 cycles high reads 15 with sat
    exp_q.push_back(4'd15);
    pulse(20);
    check_result("sat", 1'b1, 1'b1);
    tick(1'b0, 1'b0);

    // slot full: second result dropped, first held
    ready = 1'b0;
    exp_q.push_back(4'd3);
    pulse(3);
    check_result("hold3", 1'b1, 1'b0);
    check("hold3_drop", 32'(drop), 32'd0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    pulse(7);
    check("drop_pulse", 32'(drop), 32'd1);
    check("drop_width", 32'(width), 32'd3);
    check("drop_valid", 32'(valid), 32'd1);
    tick(1'b0, 1'b0);
    check("drop_once", 32'(drop), 32'd0);
    check("drop_hold", 32'(width), 32'd3);
    ready = 1'b1;
    tick(1'b0, 1'b0);
    check("drain_valid", 32'(valid), 32'd0);

    // enable dropped mid-pulse: abort silently
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    en = 1'b0;
    tick(1'b0, 1'b0);
    check("abort_state", 32'(state), 32'(IDLE));
    en = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_drop",  32'(drop),  32'd0);
    exp_q.push_back(4'd4);
    pulse(4);
    check_result("after_abort", 1'b1, 1'b0);
    tick(1'b0, 1'b0);

    // clear during MEAS_HI with a result held
    ready = 1'b0;
    exp_q.push_back(4'd2);
    pulse(2);
    check_result("pre_clr", 1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    clr = 1'b1;
    tick(1'b0, 1'b0);
    clr = 1'b0;
    check("clr_valid", 32'(valid), 32'd0);
    check("clr_width", 32'(width), 32'd0);
    check("clr_state", 32'(state), 32'(IDLE));
    tick(1'b0, 1'b1);
    check("clr_f_valid", 32'(valid), 32'd0);
    check("clr_f_drop",  32'(drop),  32'd0);

    // completion while draining: new result loaded, valid stays high
    exp_q.push_back(4'd3);
    pulse(3);
    check_result("b2b_first", 1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    ready = 1'b1;
    exp_q.push_back(4'd2);
    tick(1'b0, 1'b1);
    check_result("b2b_second", 1'b1, 1'b0);
    check("b2b_drop", 32'(drop), 32'd0);
    tick(1'b0, 1'b0);
    check("b2b_valid_clr", 32'(valid), 32'd0);

    // stray rising edge during MEAS_HI is ignored
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    exp_q.push_back(4'd4);
    tick(1'b0, 1'b1);
    check_result("stray_r", 1'b1, 1'b0);
    tick(1'b0, 1'b0);

    // simultaneous edges: rising wins in IDLE, falling wins in MEAS_HI
    tick(1'b1, 1'b1);
    check("simul_idle_state", 32'(state), 32'(MEAS_HI));
    exp_q.push_back(4'd1);
    tick(1'b1, 1'b1);
    check_result("simul_meas", 1'b1, 1'b0);
    check("simul_meas_state", 32'(state), 32'(IDLE));
    tick(1'b0, 1'b0);

    // edges ignored in IDLE while disabled
    en = 1'b0;
    tick(1'b1, 1'b0);
    check("en_idle_state", 32'(state), 32'(IDLE));
    en = 1'b1;
    tick(1'b0, 1'b1);
    check("en_idle_valid", 32'(valid), 32'd0);
`else
    // r@0, f@4, r@10 -> (4, high)@5 then (6, low)@11
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    exp_q.push_back(4'd4);
    tick(1'b0, 1'b1);
    check_result("low_hi4", 1'b1, 1'b0);
    check("low_state_lo", 32'(state), 32'(MEAS_LO));
    repeat (5) tick(1'b0, 1'b0);
    check("low_gap_valid", 32'(valid), 32'd0);
    exp_q.push_back(4'd6);
    tick(1'b1, 1'b0);
    check_result("low_lo6", 1'b0, 1'b0);
    check("low_state_hi", 32'(state), 32'(MEAS_HI));

    // IDLE accepts a falling edge and measures the low phase
    clr = 1'b1;
    tick(1'b0, 1'b0);
    clr = 1'b0;
    check("low_clr_state", 32'(state), 32'(IDLE));
    tick(1'b0, 1'b1);
    check("low_idle_f_state", 32'(state), 32'(MEAS_LO));
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    exp_q.push_back(4'd3);
    tick(1'b1, 1'b0);
    check_result("low_lo3", 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
